// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging NUM_REQ valid/ready streams onto one registered output; optional packet lock via STREAM_ARB_PKT_LOCK_EN.
// Latency: 2 cycles from valid_s in IDLE to valid_m; 1 beat/cycle while a grant is held; one bubble between grants.
// Backpressure: ready_s[gnt] follows (!valid_m || ready_m); output beat held stable while valid_m && !ready_m.
module stream_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [2**ID_WIDTH-1:0]               valid_s,
  output logic [2**ID_WIDTH-1:0]               ready_s,
  input  logic [(2**ID_WIDTH)*DATA_WIDTH-1:0]  data_s,
  input  logic [2**ID_WIDTH-1:0]               last_s,
  input  logic                                 ready_m,
  output logic                                 valid_m,
  output logic [DATA_WIDTH-1:0]                data_m,
  output logic                                 last_m,
  output logic [ID_WIDTH-1:0]                  grant_id
);

  localparam int NUM_REQ = 2**ID_WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state, state_nxt;
  logic [ID_WIDTH-1:0] ptr;
  logic [ID_WIDTH-1:0] gnt;
  logic [ID_WIDTH-1:0] winner;
  logic [ID_WIDTH-1:0] idx;
  logic                any_valid;
  logic                slot_open;
  logic                accept;
  logic                grant_done;

  // Rotating-priority search: lowest offset from ptr with valid_s set wins.
  // Index arithmetic wraps naturally because NUM_REQ is a power of two.
  always_comb begin
    winner    = ptr;
    idx       = ptr;
    any_valid = |valid_s;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + ID_WIDTH'(i);
      if (valid_s[idx]) winner = idx;
    end
  end

  // Next-state, per-requester ready and grant termination.
  always_comb begin
    state_nxt  = state;
    ready_s    = '0;
    slot_open  = !valid_m || ready_m;
    accept     = 1'b0;
    grant_done = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) state_nxt = BUSY;
      end
      BUSY: begin
        ready_s[gnt] = slot_open;
        accept       = valid_s[gnt] && slot_open;
`ifdef STREAM_ARB_PKT_LOCK_EN
        // Grant is held across requester gaps until the packet's last beat.
        grant_done   = accept && last_s[gnt];
`else
        // Every accepted beat releases the grant for re-arbitration.
        grant_done   = accept;
`endif
        if (grant_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant owner and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_valid) gnt <= winner;
      if (grant_done) ptr <= gnt + 1'b1;
    end
  end

  // Output beat register: load on accept, drain when downstream takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_m  <= 1'b0;
      data_m   <= '0;
      last_m   <= 1'b0;
      grant_id <= '0;
    end else if (accept) begin
      valid_m  <= 1'b1;
      data_m   <= data_s[gnt*DATA_WIDTH +: DATA_WIDTH];
      last_m   <= last_s[gnt];
      grant_id <= gnt;
    end else if (ready_m) begin
      valid_m  <= 1'b0;
    end
  end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, default 8, width of each data beat.
REQ-002 SHALL have parameter: ID_WIDTH, default 2, grant index width; NUM_REQ = 2**ID_WIDTH requesters (2..16).
REQ-003 SHALL have port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: valid_s  input  NUM_REQ  per-requester beat valid.
REQ-006 SHALL have port: ready_s  output  NUM_REQ  per-requester beat accept.
REQ-007 SHALL have port: data_s  input  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port: last_s  input  NUM_REQ  per-requester end-of-packet flag.
REQ-009 SHALL have port: ready_m  input  1  downstream accept.
REQ-010 SHALL have port: valid_m  output  1  registered output valid.
REQ-011 SHALL have port: data_m  output  DATA_WIDTH  registered output data.
REQ-012 SHALL have port: last_m  output  1  registered output end-of-packet.
REQ-013 SHALL have port: grant_id  output  ID_WIDTH  index of the requester owning the current/last output beat.

Function
REQ-014 SHALL implement FSM with states IDLE and BUSY; reset state IDLE.
REQ-015 SHALL, in IDLE, drive ready_s = 0 and select winner = first i with valid_s[i]=1 searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
REQ-016 SHALL, in IDLE with any valid_s set, register gnt = winner and move to BUSY on the next edge; no valid_s -> stay IDLE.
REQ-017 SHALL, in BUSY, drive ready_s[gnt] = (!valid_m || ready_m) combinationally; all other ready_s bits 0.
REQ-018 SHALL, on accept (valid_s[gnt] && ready_s[gnt]), load data_s[gnt], last_s[gnt] into data_m/last_m, set valid_m=1, grant_id=gnt on the next edge.
REQ-019 SHALL clear valid_m when ready_m=1 and no new beat is accepted that cycle; valid_m/data_m/last_m held stable while valid_m && !ready_m.
REQ-020 SHALL, on accepting a beat that terminates the grant (REQ-030/031), return to IDLE and set ptr = gnt+1 (wraps NUM_REQ-1 -> 0).
REQ-021 SHALL stay BUSY while valid_s[gnt]=0 (requester gaps do not release grant).
REQ-022 SHALL deliver latency: valid_s rising in IDLE with output empty -> valid_m 2 cycles later; in BUSY, 1 beat/cycle sustained with ready_m=1.
REQ-023 SHALL incur exactly one idle output cycle (arbitration bubble) between consecutive grants when ready_m=1.
REQ-024 SHALL ignore valid_s changes of non-granted requesters while BUSY.
REQ-025 SHALL never drop or duplicate beats, including simultaneous accept-in and drain-out in one cycle.

Reset
REQ-026 SHALL, while rst=1, force state IDLE, ptr=0, gnt=0, ready_s=0, valid_m=0, data_m=0, last_m=0, grant_id=0, regardless of clk.
REQ-027 SHALL, on rst asserted mid-packet, discard any held beat and partial grant; first grant after release follows ptr=0.
REQ-028 SHALL not accept any beat in the first clk edge after rst deasserts (ready_s=0 in IDLE).

Configuration
REQ-029 SHALL use macro STREAM_ARB_PKT_LOCK_EN to select grant termination.
REQ-030 SHALL, with STREAM_ARB_PKT_LOCK_EN defined, hold grant until an accepted beat with last_s[gnt]=1 (packet lock).
REQ-031 SHALL, without STREAM_ARB_PKT_LOCK_EN, terminate grant after every accepted beat; last_s still forwarded to last_m unchanged.

Verification
REQ-032 SHALL cover: reset, then valid_s=4'b0001, data 0xA5, last=1, ready_m=1 -> valid_m=1, data_m=0xA5, grant_id=0 at cycle 2, ptr=1.
REQ-033 SHALL cover: all four valid_s=1, single-beat packets, ready_m=1 -> grant_id sequence 0,1,2,3,0 with one bubble between each.
REQ-034 SHALL cover (LOCK_EN): req1 sends 3-beat packet 0x11,0x12,0x13(last) while req0 valid -> output 0x11,0x12,0x13 contiguous from req1 before any req0 beat.
REQ-035 SHALL cover: ready_m=0 for 5 cycles with valid_m=1, data 0x3C -> data_m stays 0x3C, ready_s[gnt]=0; ready_m=1 -> next beat follows at 1/cycle.
REQ-036 SHALL cover: rst pulsed asynchronously mid-packet between edges -> valid_m, ready_s drop immediately; after release, grant from ptr=0.
REQ-037 SHALL cover (no LOCK_EN): req2 3-beat packet with req3 valid -> beats interleave 2,3,2,3,2 by grant_id.
